// File: rtl/prefetch_pkg.sv
// Shared types and constants for the instruction prefetch queue.
//   state_e    : fetch FSM states
//   PC_INC     : byte stride between consecutive instructions
//   ALIGN_MASK : low PC bits that are always forced to zero
package prefetch_pkg;

  typedef enum logic [1:0] {
    IDLE,  // no request outstanding
    WAIT,  // request outstanding at fetch_pc, response will be pushed
    DROP   // request outstanding, response is stale and will be discarded
  } state_e;

  localparam int unsigned PC_INC     = 4;
  localparam int unsigned ALIGN_MASK = 3;

endpackage

// File: rtl/prefetch_fifo.sv
// DEPTH-entry FIFO of {pc, inst} pairs with registered head outputs.
//   clk, rst          : clock, synchronous active-high reset
//   push_i/pc_i/inst_i: write one entry (ignored when full or flushing)
//   pop_i             : consume the head entry (ignored when empty)
//   flush_i           : empty the FIFO; a same-cycle pop still counts as delivered
//   count_o           : current occupancy
//   valid_o/pc_o/inst_o: head entry, zero when empty
module prefetch_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [DATA_WIDTH-1:0]      pc_i,
  input  logic [DATA_WIDTH-1:0]      inst_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       valid_o,
  output logic [DATA_WIDTH-1:0]      pc_o,
  output logic [DATA_WIDTH-1:0]      inst_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem_pc_q, mem_inst_q;
  logic [PW-1:0]         rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d, inst_q, inst_d;
  logic                  do_push, do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && !flush_i && (count_q != CW'(DEPTH));

  always_comb begin
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    valid_d = 1'b0;
    pc_d    = '0;
    inst_d  = '0;
    if (flush_i) begin
      rd_d    = '0;
      wr_d    = '0;
      count_d = '0;
    end else begin
      if (do_pop)  rd_d = rd_q + PW'(1);
      if (do_push) wr_d = wr_q + PW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
    valid_d = (count_d != '0);
    // Next head is the entry being written this cycle when the FIFO
    // would otherwise be empty; storage is not yet updated for it.
    if (valid_d) begin
      if (do_push && (wr_q == rd_d)) begin
        pc_d   = pc_i;
        inst_d = inst_i;
      end else begin
        pc_d   = mem_pc_q[rd_d];
        inst_d = mem_inst_q[rd_d];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_pc_q[wr_q]   <= pc_i;
      mem_inst_q[wr_q] <= inst_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      pc_q    <= '0;
      inst_q  <= '0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
      valid_q <= valid_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
    end
  end

  assign count_o = count_q;
  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign inst_o  = inst_q;

endmodule

// File: rtl/prefetch_queue.sv
// Instruction prefetch unit: streams fetch requests into a DEPTH-entry
// FIFO of {pc, inst}, flushing and dropping in-flight data on redirect.
//   clk, rst                 : clock, synchronous active-high reset
//   inst_req/inst_addr       : level fetch request, address held while high
//   inst_valid/inst_data     : response strobe and fetched word
//   branch_flag/new_pc       : one-cycle redirect, target word-aligned here
//   out_valid/out_ready      : decode handshake on the FIFO head
//   out_inst/out_pc          : head instruction and its PC, zero when empty
module prefetch_queue
  import prefetch_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  inst_req,
  output logic [DATA_WIDTH-1:0] inst_addr,
  input  logic                  inst_valid,
  input  logic [DATA_WIDTH-1:0] inst_data,
  input  logic                  branch_flag,
  input  logic [DATA_WIDTH-1:0] new_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_inst,
  output logic [DATA_WIDTH-1:0] out_pc
);
  localparam int CW = $clog2(DEPTH+1);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic [CW-1:0]         fifo_count, count_next;
  logic                  pop, push, flush;

  assign pop        = out_valid && out_ready;
  assign count_next = fifo_count - CW'(pop);

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    push       = 1'b0;
    flush      = 1'b0;
    if (branch_flag) begin
      flush      = 1'b1;
      fetch_pc_d = new_pc & ~DATA_WIDTH'(ALIGN_MASK);
      // An outstanding request must still see its response before a new
      // one can issue; a response arriving now is simply thrown away.
      if (state_q != IDLE) state_d = inst_valid ? IDLE : DROP;
      else                 state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: if (count_next < CW'(DEPTH)) state_d = WAIT;
        WAIT: if (inst_valid) begin
          push       = 1'b1;
          fetch_pc_d = fetch_pc_q + DATA_WIDTH'(PC_INC);
          state_d    = (({1'b0, count_next} + (CW+1)'(1)) < (CW+1)'(DEPTH)) ? WAIT : IDLE;
        end
        DROP: if (inst_valid) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
    // The bus address must not move while the stale request is pending.
    addr_d = (state_d == DROP) ? addr_q : fetch_pc_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
    end
  end

  assign inst_req  = (state_q != IDLE);
  assign inst_addr = addr_q;

  prefetch_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pc_i    (fetch_pc_q),
    .inst_i  (inst_data),
    .pop_i   (pop),
    .flush_i (flush),
    .count_o (fifo_count),
    .valid_o (out_valid),
    .pc_o    (out_pc),
    .inst_o  (out_inst)
  );

endmodule
